// File: rtl/shift_issue_stage_pkg.sv
// Shared definitions for the shift issue/retire stage: op encodings seen by
// the external shift unit and the request-op canonicalisation.
package shift_issue_stage_pkg;

   // Codes the shift unit understands; su_op only ever carries one of these.
   typedef enum logic [2:0] {
      OP_ROTL = 3'b000,
      OP_ROTR = 3'b001,
      OP_SLL  = 3'b010,
      OP_SRL  = 3'b011,
      OP_SRA  = 3'b111
   } su_op_e;

   // Arithmetic left shift is identical to logical left shift, so the three
   // sla codes (and 010 itself) all collapse onto OP_SLL.
   function automatic su_op_e canon_op(input logic [2:0] op);
      su_op_e res;
      case (op)
         3'b000:  res = OP_ROTL;
         3'b001:  res = OP_ROTR;
         3'b011:  res = OP_SRL;
         3'b111:  res = OP_SRA;
         default: res = OP_SLL;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/shift_issue_stage_pipe_reg.sv
// One pipeline slot: a valid bit plus a payload register. Flush beats load,
// load beats clear; the payload only changes on an accepted load.
module pipe_reg_stage #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush_i,
   input  logic         load_i,
   input  logic         clear_i,
   input  logic [W-1:0] data_i,
   output logic         valid_o,
   output logic [W-1:0] data_o
);

   logic         valid_d, valid_q;
   logic [W-1:0] data_d, data_q;

   // Next-state selection for the slot: flush, then load, then clear.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end else if (clear_i) begin
         valid_d = 1'b0;
      end
   end

   // Slot registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/shift_issue_stage.sv
// Registered issue (S1) / retire (S2) wrapper around an external
// combinational 32-bit shift unit, with a saturating completion counter.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A producer holds valid and its payload until that edge; ready
// never depends combinationally on the same port's valid. Here in_ready is a
// function of the stage state, out_ready and flush only.
module shift_issue_stage
   import shift_issue_stage_pkg::*;
#(
   parameter int TAG_W = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_a,
   input  logic [4:0]       in_b,
   input  logic [2:0]       in_op,
   input  logic [TAG_W-1:0] in_tag,
   output logic [31:0]      su_a,
   output logic [4:0]       su_b,
   output logic [2:0]       su_op,
   input  logic [31:0]      su_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_result,
   output logic [TAG_W-1:0] out_tag,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] done_count
);

   localparam int S1_W = 32 + 5 + 3 + TAG_W;
   localparam int S2_W = 32 + TAG_W;

   logic             s1_valid_q, s2_valid_q;
   logic [S1_W-1:0]  s1_data_d, s1_data_q;
   logic [S2_W-1:0]  s2_data_d, s2_data_q;
   logic             s1_adv, s2_adv, s1_load, s2_load;
   logic [TAG_W-1:0] s1_tag;
   su_op_e           in_op_canon;
   logic             done_inc;
   logic [CNT_W-1:0] done_count_d, done_count_q;

   // Stall chain: a slot may take new data when it is empty or its
   // occupant leaves this cycle, so S2 draining lets S1 pass straight through.
   always_comb begin
      s2_adv   = !s2_valid_q || out_ready;
      s1_adv   = !s1_valid_q || s2_adv;
      in_ready = s1_adv && !flush;
      s1_load  = in_valid && in_ready;
      s2_load  = s1_valid_q && s2_adv;
   end

   // Capture payloads: canonical op into S1, unit result plus S1 tag into S2.
   always_comb begin
      in_op_canon = canon_op(in_op);
      s1_data_d   = {in_a, in_b, in_op_canon, in_tag};
      s2_data_d   = {su_result, s1_tag};
   end

   pipe_reg_stage #(.W(S1_W)) u_s1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (flush),
      .load_i  (s1_load),
      .clear_i (s1_adv),
      .data_i  (s1_data_d),
      .valid_o (s1_valid_q),
      .data_o  (s1_data_q)
   );

   pipe_reg_stage #(.W(S2_W)) u_s2 (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (flush),
      .load_i  (s2_load),
      .clear_i (out_ready),
      .data_i  (s2_data_d),
      .valid_o (s2_valid_q),
      .data_o  (s2_data_q)
   );

   assign {su_a, su_b, su_op, s1_tag} = s1_data_q;
   assign {out_result, out_tag}       = s2_data_q;
   assign out_valid                   = s2_valid_q;
   assign occupancy                   = {1'b0, s1_valid_q} + {1'b0, s2_valid_q};

   // Count completed output handshakes; a flush cycle does not count and
   // the counter sticks at all-ones.
   always_comb begin
      done_inc     = s2_valid_q && out_ready && !flush && (done_count_q != '1);
      done_count_d = done_inc ? done_count_q + 1'b1 : done_count_q;
   end

   // Completion counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_count_q <= '0;
      end else begin
         done_count_q <= done_count_d;
      end
   end

   assign done_count = done_count_q;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Bench for shift_issue_stage: a behavioural shift unit closes the loop,
// a negedge monitor scoreboards every output against a reference model.
module tb_shift_issue_stage;

   localparam int TAG_W = 4;
   localparam int CNT_W = 4;
   localparam int MAXC  = (1 << CNT_W) - 1;

   logic             clk;
   logic             rst_n;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_a;
   logic [4:0]       in_b;
   logic [2:0]       in_op;
   logic [TAG_W-1:0] in_tag;
   logic [31:0]      su_a;
   logic [4:0]       su_b;
   logic [2:0]       su_op;
   logic [31:0]      su_result;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_result;
   logic [TAG_W-1:0] out_tag;
   logic [1:0]       occupancy;
   logic [CNT_W-1:0] done_count;

   logic             dir_ready;
   logic             rnd_ready;
   logic             rand_en;

   int n_checks;
   int n_errors;
   int exp_done;
   logic [TAG_W+31:0] exp_q[$];
   logic              prev_stall;
   logic [TAG_W+31:0] prev_word;

   assign out_ready = rand_en ? rnd_ready : dir_ready;

   shift_issue_stage #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_op      (in_op),
      .in_tag     (in_tag),
      .su_a       (su_a),
      .su_b       (su_b),
      .su_op      (su_op),
      .su_result  (su_result),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_tag    (out_tag),
      .occupancy  (occupancy),
      .done_count (done_count)
   );

   // Shift unit stand-in: only the five canonical codes are meaningful.
   always_comb begin
      case (su_op)
         3'b000:  su_result = (su_a << su_b) | (su_a >> (6'd32 - {1'b0, su_b}));
         3'b001:  su_result = (su_a >> su_b) | (su_a << (6'd32 - {1'b0, su_b}));
         3'b010:  su_result = su_a << su_b;
         3'b011:  su_result = su_a >> su_b;
         3'b111:  su_result = $signed(su_a) >>> su_b;
         default: su_result = 32'hDEAD_BEEF;
      endcase
   end

   // Reference: result of a request as the requester sees it (raw op code).
   function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] b,
                                             input logic [2:0] op);
      logic [63:0] dbl;
      logic [31:0] res;
      dbl = {a, a};
      case (op)
         3'b000:  begin dbl = dbl << b; res = dbl[63:32]; end
         3'b001:  begin dbl = dbl >> b; res = dbl[31:0]; end
         3'b011:  res = a >> b;
         3'b111:  res = $signed(a) >>> b;
         default: res = a << b;
      endcase
      return res;
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Random ready generator used during the random phase.
   initial begin
      rnd_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1 rnd_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Watchdog.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // Monitor / scoreboard, sampled at negedge where everything has settled.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         exp_done   = 0;
         prev_stall = 1'b0;
      end else begin
         check("done_count", 64'(done_count), 64'(exp_done));
         check("occupancy", 64'(occupancy), 64'(exp_q.size()));
         if (prev_stall) begin
            check("held_valid", 64'(out_valid), 64'd1);
            check("held_result", 64'({out_tag, out_result}), 64'(prev_word));
         end
         if (flush) begin
            check("flush_in_ready", 64'(in_ready), 64'd0);
            exp_q.delete();
            prev_stall = 1'b0;
         end else begin
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  check("stray_out_valid", 64'(out_valid), 64'd0);
               end else begin
                  check("result", 64'({out_tag, out_result}), 64'(exp_q.pop_front()));
               end
               if (exp_done < MAXC) exp_done++;
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_tag, out_result};
            if (in_valid && in_ready)
               exp_q.push_back({in_tag, ref_shift(in_a, in_b, in_op)});
         end
      end
   end

   // Offer one request and hold it until accepted; returns 1ns after the
   // accepting edge.
   task automatic send(input logic [31:0] a, input logic [4:0] b, input logic [2:0] op,
                       input logic [TAG_W-1:0] tag);
      bit ok;
      ok       = 1'b0;
      in_a     = a;
      in_b     = b;
      in_op    = op;
      in_tag   = tag;
      in_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("send_timeout", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Wait (bounded) until nothing is in flight; returns at a negedge.
   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (occupancy == 2'd0 && exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("drain_timeout", 64'(occupancy), 64'd0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_occupancy"}, 64'(occupancy), 64'd0);
      check({tag, "_done_count"}, 64'(done_count), 64'd0);
      check({tag, "_out_result"}, 64'(out_result), 64'd0);
      check({tag, "_out_tag"}, 64'(out_tag), 64'd0);
      check({tag, "_su_a"}, 64'(su_a), 64'd0);
      check({tag, "_su_b"}, 64'(su_b), 64'd0);
      check({tag, "_su_op"}, 64'(su_op), 64'd0);
      check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
   endtask

   // Main stimulus sequence.
   initial begin
      n_checks   = 0;
      n_errors   = 0;
      exp_done   = 0;
      prev_stall = 1'b0;
      prev_word  = '0;
      rst_n      = 1'b1;
      flush      = 1'b0;
      in_valid   = 1'b0;
      in_a       = '0;
      in_b       = '0;
      in_op      = '0;
      in_tag     = '0;
      dir_ready  = 1'b0;
      rand_en    = 1'b0;
      #1 rst_n = 1'b0;
      #2 check_reset_values("reset");
      #19 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Rotate-left latency: result visible after the next edge.
      dir_ready = 1'b1;
      send(32'h8000_0001, 5'd1, 3'b000, 4'd1);
      @(posedge clk);
      #1;
      check("lat_out_valid", 64'(out_valid), 64'd1);
      check("lat_out_result", 64'(out_result), 64'h0000_0003);
      check("lat_out_tag", 64'(out_tag), 64'd1);
      @(posedge clk);
      #1;
      check("lat_done_count", 64'(done_count), 64'd1);
      check("lat_out_valid_clear", 64'(out_valid), 64'd0);

      // Back-to-back sra then srl, no bubble.
      send(32'hF000_0000, 5'd4, 3'b111, 4'd2);
      send(32'hF000_0000, 5'd4, 3'b011, 4'd3);
      check("b2b_first_valid", 64'(out_valid), 64'd1);
      check("b2b_first", 64'({out_tag, out_result}), {28'd0, 4'd2, 32'hFF00_0000});
      @(posedge clk);
      #1;
      check("b2b_second_valid", 64'(out_valid), 64'd1);
      check("b2b_second", 64'({out_tag, out_result}), {28'd0, 4'd3, 32'h0F00_0000});
      wait_idle();
      check("b2b_done_count", 64'(done_count), 64'd3);
      @(posedge clk);
      #1;

      // Back-pressure with three requests offered.
      dir_ready = 1'b0;
      send(32'h1234_5678, 5'd8, 3'b000, 4'd4);
      send(32'h8765_4321, 5'd3, 3'b111, 4'd5);
      fork
         send(32'h0000_00FF, 5'd30, 3'b100, 4'd6);
         begin
            #2;
            check("bp_occupancy", 64'(occupancy), 64'd2);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_held", 64'({out_tag, out_result}), {28'd0, 4'd4, 32'h3456_7812});
            repeat (3) @(posedge clk);
            #1;
            check("bp_occupancy_late", 64'(occupancy), 64'd2);
            check("bp_held_late", 64'({out_tag, out_result}), {28'd0, 4'd4, 32'h3456_7812});
            dir_ready = 1'b1;
         end
      join
      wait_idle();
      check("bp_done_count", 64'(done_count), 64'd6);
      @(posedge clk);
      #1;

      // sla canonicalisation.
      send(32'h0000_0001, 5'd31, 3'b101, 4'd7);
      check("canon_su_op", 64'(su_op), 64'b010);
      check("canon_su_b", 64'(su_b), 64'd31);
      @(posedge clk);
      #1;
      check("canon_result", 64'(out_result), 64'h8000_0000);
      wait_idle();
      check("canon_done_count", 64'(done_count), 64'd7);
      @(posedge clk);
      #1;

      // Flush with two ops held.
      dir_ready = 1'b0;
      send(32'h0000_0F0F, 5'd2, 3'b010, 4'd8);
      send(32'h0000_F0F0, 5'd5, 3'b011, 4'd9);
      check("flush_pre_occupancy", 64'(occupancy), 64'd2);
      flush = 1'b1;
      #1 check("flush_blocks_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1 flush = 1'b0;
      check("flush_occupancy", 64'(occupancy), 64'd0);
      check("flush_out_valid", 64'(out_valid), 64'd0);
      check("flush_done_count", 64'(done_count), 64'd7);
      dir_ready = 1'b1;
      send(32'hA5A5_0000, 5'd16, 3'b001, 4'd10);
      @(posedge clk);
      #1 check("post_flush_result", 64'(out_result), 64'h0000_A5A5);
      wait_idle();
      check("post_flush_done_count", 64'(done_count), 64'd8);
      @(posedge clk);
      #1;

      // Asynchronous reset between edges with work in flight.
      dir_ready = 1'b0;
      send(32'h1111_2222, 5'd7, 3'b000, 4'd11);
      send(32'h3333_4444, 5'd9, 3'b001, 4'd12);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1 check_reset_values("midreset");
      #3 rst_n = 1'b1;
      dir_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("midreset_no_stray", 64'(out_valid), 64'd0);
      end
      @(posedge clk);
      #1;

      // Random phase: random ops, gaps, ready and occasional flush.
      rand_en = 1'b1;
      for (int n = 0; n < 300; n++) begin
         int gap;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
         end
         if ($urandom_range(0, 39) == 0) begin
            flush = 1'b1;
            @(posedge clk);
            #1 flush = 1'b0;
         end
         send($urandom, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
              TAG_W'($urandom_range(0, MAXC)));
      end
      rand_en = 1'b0;
      dir_ready = 1'b1;
      wait_idle();

      // Saturation: counter already at all-ones must stay there.
      check("sat_before", 64'(done_count), 64'(MAXC));
      @(posedge clk);
      #1;
      send(32'hCAFE_F00D, 5'd12, 3'b110, 4'd3);
      wait_idle();
      check("sat_after", 64'(done_count), 64'(MAXC));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/shift_issue_stage.md
Name: shift_issue_stage

Overview:
- Registered issue/retire wrapper in front of the team's combinational 32-bit shift/rotate unit.
- Accepts shift requests over a valid/ready handshake and holds operands stable in an issue register (S1) that drives the shift unit.
- Captures the unit's result in a retire register (S2) and presents it downstream over a second valid/ready handshake.
- Full throughput (1 op/cycle) with back-pressure; also keeps a completed-op counter for the perf block.

Parameters:
- TAG_W, 4, width of the request tag carried alongside each operation
- CNT_W, 16, width of the saturating completed-op counter

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous flush; drops all in-flight ops
- in_valid  in  1  request valid
- in_ready  out  1  stage can accept a request this cycle
- in_a  in  32  operand, signed
- in_b  in  5  shift amount
- in_op  in  3  000 rotl, 001 rotr, 010 sll, 011 srl, 111 sra, 100/101/110 sla
- in_tag  in  TAG_W  request tag
- su_a  out  32  S1 operand to shift unit
- su_b  out  5  S1 amount to shift unit
- su_op  out  3  S1 canonical op to shift unit
- su_result  in  32  combinational result from shift unit
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_result  out  32  registered result
- out_tag  out  TAG_W  tag of out_result
- occupancy  out  2  ops held in S1+S2 (0..2)
- done_count  out  CNT_W  completed handshakes, saturating

Behaviour:
- Reset (rst_n low, async): s1_valid=0, s2_valid=0; su_a/su_b/su_op/out_result/out_tag=0; done_count=0; occupancy=0. in_ready rises combinationally once s1_valid=0.
- Op canonicalisation at capture: 100/101/110 are stored as 010 (sla == sll). All other codes pass unchanged, so su_op is only ever 000, 001, 010, 011 or 111.
- Stall chain:
  - s2_adv = !s2_valid | out_ready
  - s1_adv = !s1_valid | s2_adv
  - in_ready = s1_adv
  - in_ready is combinational from out_ready; this is accepted, and there is no combinational in_valid->in_ready path.
- S1 load: on in_valid & in_ready, capture a/b/canonical op/tag and set s1_valid=1. If s1_adv and no request, clear s1_valid.
- S2 load: on s1_valid & s2_adv, capture su_result and the S1 tag and set s2_valid=1. Else if out_ready & s2_valid, clear s2_valid.
- Data holds: S1 and S2 data registers hold their value when not loading. su_* stay stable while S1 is stalled.
- Latency: a request accepted at edge N appears on out_valid/out_result after edge N+1 when there is no stall.
- Throughput: back-to-back ops at one per cycle with out_ready=1.
- Stall: out_valid & !out_ready freezes S2. A valid S1 also freezes and in_ready=0. The held result and tag are unchanged until the handshake.
- done_count: +1 on each out_valid & out_ready. It saturates at all-ones and does not wrap.
- occupancy = s1_valid + s2_valid.
- flush (synchronous) clears s1_valid and s2_valid, has priority over every load that cycle, and does not increment done_count for that cycle. in_ready is forced to 0 while flush=1.
- Reset mid-operation: all valids drop immediately. No result is emitted afterward for ops in flight.
- Simultaneous S2 drain and S1 advance in one cycle is a legal pass-through; no bubble is inserted.

Decomposition:
- Shared package:
  - op encodings: OP_ROTL=3'b000, OP_ROTR=3'b001, OP_SLL=3'b010, OP_SRL=3'b011, OP_SRA=3'b111
  - canonicalisation function
- The shift unit stays external and is not instantiated here, so either ALU variant can be bound.
- Optional sub-module: pipe_reg_stage (valid/data register with advance/flush), instantiated twice for S1 and S2.

Test Plan:
- Reset, then in_a=32'h8000_0001, in_b=1, op=000, out_ready=1 -> after 2 edges out_valid=1, out_result=32'h0000_0003, done_count=1.
- Back-to-back sra then srl: a=32'hF000_0000, b=4, ops 111 then 011 -> consecutive cycles give results 32'hFF00_0000 then 32'h0F00_0000, tags in order, no bubble.
- Back-pressure: out_ready=0 with 3 requests offered -> occupancy reaches 2, in_ready=0, out_result held stable. Raising out_ready drains all 3 in order, and done_count increases by 3.
- Canonicalisation: in_op=101, a=32'h1, b=31 -> su_op observed as 010, result 32'h8000_0000.
- Flush with occupancy=2 -> next cycle occupancy=0, out_valid=0, done_count unchanged. A new request after flush completes normally.
- Async reset asserted mid-stream between clock edges -> outputs and done_count go to 0 immediately, with no stray out_valid after release. Separately, force done_count to all-ones and complete an op -> done_count stays saturated.
